// File: rtl/multiplier_5by5_acc.sv
// Serial 5x5 multiply-accumulate, P = Q*D + R, unsigned. Rebuilds a 10-by-5 divide's dividend.
// Optional MUL_RANGE_CHECK_EN: flag operands a divider could not produce (R >= D).
module multiplier_5by5_acc (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [4:0] dataIN,
   output logic [4:0] dataOUT,
   output logic       done,
   output logic       busy,
   output logic       err
);

   typedef enum logic [2:0] {IDLE, LD_D, LD_R, MUL, OUT_HI, OUT_LO} state_t;

   state_t     state;
   logic [4:0] qReg;
   logic [4:0] dReg;
   logic [4:0] rReg;
   logic [9:0] acc;
   logic [2:0] iter;
   logic [9:0] accStep;
   logic       rangeErr;

   // One shift-add step; the last step's result feeds dataOUT directly so OUT_HI is registered.
   always_comb begin
      accStep = acc;
      if (qReg[iter])
         accStep = acc + ({5'b0, dReg} << iter);
   end

`ifdef MUL_RANGE_CHECK_EN
   assign rangeErr = (rReg >= dReg);
`else
   assign rangeErr = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         qReg    <= '0;
         dReg    <= '0;
         rReg    <= '0;
         acc     <= '0;
         iter    <= '0;
         dataOUT <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
      end else begin
         dataOUT <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  qReg  <= dataIN;
                  busy  <= 1'b1;
                  state <= LD_D;
               end
            end
            LD_D: begin
               dReg  <= dataIN;
               state <= LD_R;
            end
            LD_R: begin
               rReg  <= dataIN;
               acc   <= {5'b0, dataIN};
               iter  <= '0;
               state <= MUL;
            end
            MUL: begin
               acc <= accStep;
               if (iter == 3'd4) begin
                  dataOUT <= accStep[9:5];
                  done    <= 1'b1;
                  err     <= rangeErr;
                  state   <= OUT_HI;
               end else begin
                  iter <= iter + 3'd1;
               end
            end
            OUT_HI: begin
               dataOUT <= acc[4:0];
               done    <= 1'b1;
               err     <= rangeErr;
               state   <= OUT_LO;
            end
            OUT_LO: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier_5by5_acc.sv
// Bench for multiplier_5by5_acc: timeline reference model plus directed literal cases.
// Honours MUL_RANGE_CHECK_EN for the expected err flag.
module tb_multiplier_5by5_acc;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] dataIN;
   logic [4:0] dataOUT;
   logic       done;
   logic       busy;
   logic       err;

   int tests = 0;
   int fails = 0;
   bit armed = 1'b0;

   multiplier_5by5_acc dut (
      .clk(clk), .rst(rst), .start(start), .dataIN(dataIN),
      .dataOUT(dataOUT), .done(done), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
      end
   endtask

   // Reference: ph counts edges since the accepted start (0 = idle).
   // Edge 0 takes Q, edge 1 takes D, edge 2 takes R; result halves follow edges 7 and 8.
   int         ph = 0;
   logic [4:0] mq = '0, md = '0, mr = '0;

   always @(posedge clk) begin
      if (rst) begin
         ph = 0; mq = '0; md = '0; mr = '0;
      end else if (ph == 0) begin
         if (start) begin
            ph = 1; mq = dataIN;
         end
      end else begin
         ph = ph + 1;
         if (ph == 2) md = dataIN;
         if (ph == 3) mr = dataIN;
         if (ph == 10) ph = 0;
      end
   end

   always @(negedge clk) begin
      int         p;
      logic [4:0] eOut;
      logic       eDone, eErr;
      if (armed) begin
         p     = int'(mq) * int'(md) + int'(mr);
         eDone = (ph == 8) || (ph == 9);
         eOut  = (ph == 8) ? 5'((p >> 5) & 31) : (ph == 9) ? 5'(p & 31) : 5'd0;
`ifdef MUL_RANGE_CHECK_EN
         eErr  = eDone && (mr >= md);
`else
         eErr  = 1'b0;
`endif
         chk("busy", {9'b0, busy}, {9'b0, ph != 0});
         chk("done", {9'b0, done}, {9'b0, eDone});
         chk("dataOUT", {5'b0, dataOUT}, {5'b0, eOut});
         chk("err", {9'b0, err}, {9'b0, eErr});
      end
   end

   task automatic runTxn(input logic [4:0] q, input logic [4:0] d, input logic [4:0] r,
                         output logic [4:0] hi, output logic [4:0] lo, output logic e,
                         output int lat);
      @(negedge clk); start = 1'b1; dataIN = q;
      @(negedge clk); start = 1'b0; dataIN = d;
      @(negedge clk); dataIN = r;
      lat = 0;
      do begin
         @(negedge clk); dataIN = 5'($urandom); lat++;
      end while (done !== 1'b1 && lat < 20);
      hi = dataOUT; e = err;
      @(negedge clk); dataIN = 5'($urandom);
      lo = dataOUT;
      chk("doneSecond", {9'b0, done}, 10'd1);
      @(negedge clk);
      chk("doneDrop", {9'b0, done}, 10'd0);
   endtask

   initial begin
      logic [4:0] hi, lo;
      logic       e;
      int         lat, cnt, first, second;
      logic       prevDone;

      rst = 1'b1; start = 1'b1; dataIN = 5'd17;
      @(negedge clk);
      armed = 1'b1;
      @(negedge clk);
      chk("rstDataOUT", {5'b0, dataOUT}, 10'd0);
      chk("rstDone", {9'b0, done}, 10'd0);
      chk("rstBusy", {9'b0, busy}, 10'd0);
      chk("rstErr", {9'b0, err}, 10'd0);
      rst = 1'b0; start = 1'b0;

      runTxn(5'd6, 5'd7, 5'd3, hi, lo, e, lat);
      chk("basicHi", {5'b0, hi}, 10'd1);
      chk("basicLo", {5'b0, lo}, 10'd13);
      chk("basicErr", {9'b0, e}, 10'd0);
      chk("basicLatency", 10'(lat), 10'd6);

      runTxn(5'd31, 5'd31, 5'd30, hi, lo, e, lat);
      chk("maxHi", {5'b0, hi}, 10'd30);
      chk("maxLo", {5'b0, lo}, 10'd31);
      chk("maxErr", {9'b0, e}, 10'd0);

      runTxn(5'd5, 5'd0, 5'd0, hi, lo, e, lat);
      chk("invHi", {5'b0, hi}, 10'd0);
      chk("invLo", {5'b0, lo}, 10'd0);
`ifdef MUL_RANGE_CHECK_EN
      chk("invErr", {9'b0, e}, 10'd1);
`else
      chk("invErr", {9'b0, e}, 10'd0);
`endif

      // Abort on the second MUL cycle
      @(negedge clk); start = 1'b1; dataIN = 5'd9;
      @(negedge clk); start = 1'b0; dataIN = 5'd9;
      @(negedge clk); dataIN = 5'd1;
      @(negedge clk); dataIN = 5'd0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abortBusy", {9'b0, busy}, 10'd0);
      chk("abortDone", {9'b0, done}, 10'd0);
      runTxn(5'd0, 5'd9, 5'd4, hi, lo, e, lat);
      chk("afterAbortHi", {5'b0, hi}, 10'd0);
      chk("afterAbortLo", {5'b0, lo}, 10'd4);

      // Start pulses while busy must not spawn extra transactions
      cnt = 0;
      @(negedge clk); start = 1'b1; dataIN = 5'd3;
      @(negedge clk); start = 1'b1; dataIN = 5'd4;
      @(negedge clk); start = 1'b0; dataIN = 5'd2;
      @(negedge clk); start = 1'b1; dataIN = 5'd11;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) cnt++;
      end
      chk("busyStartDoneCycles", 10'(cnt), 10'd2);

      // Held start: back-to-back transactions, one idle cycle apart
      first = -1; second = -1; prevDone = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); start = 1'b1; dataIN = 5'($urandom);
         if (done === 1'b1 && !prevDone) begin
            if (first < 0) first = i;
            else if (second < 0) second = i;
         end
         prevDone = (done === 1'b1);
      end
      chk("heldStartPeriod", 10'(second - first), 10'd10);
      start = 1'b0;
      repeat (12) @(negedge clk);

      // Random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         start  = ($urandom_range(3) == 0);
         rst    = ($urandom_range(63) == 0);
         dataIN = 5'($urandom);
      end
      rst = 1'b0; start = 1'b0;
      repeat (12) @(negedge clk);

      armed = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
